// File: rtl/pt2272_decoder_param.sv
// PT2262-style trinary frame receiver. Tick-sampled run-length pulse classification,
// parametrised address/data widths and repeat-match acceptance before publishing D.
module pt2272_decoder_param #(
    parameter int ADDR_TRITS  = 8,
    parameter int DATA_BITS   = 4,
    parameter int CLK_DIV     = 250,
    parameter int TOL         = 1,
    parameter int MATCH_COUNT = 2,
    parameter int LATCH       = 1,
    parameter int LOSS_TICKS  = 200
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2*ADDR_TRITS-1:0] A,
    input  logic                    cod_i,
    output logic [DATA_BITS-1:0]    D,
    output logic                    dv,
    output logic                    vt
);
    localparam int NSYM    = ADDR_TRITS + DATA_BITS;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W   = $clog2(NSYM + 1);
    localparam int SYNC_LO = 100;

    typedef enum logic [1:0] {HUNT, RX, CHECK} state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] x);
        return (x == 8'hFF) ? x : x + 8'd1;
    endfunction

    function automatic logic in_win(input logic [7:0] x, input int c);
        int v;
        v = int'(x);
        return (v >= c - TOL) && (v <= c + TOL);
    endfunction

    // Stage p0/p1: two-flop synchroniser on the asynchronous code input
    logic cod_p0, cod_p1;
    always_ff @(posedge clk) begin
        if (reset) begin
            cod_p0 <= 1'b0;
            cod_p1 <= 1'b0;
        end else begin
            cod_p0 <= cod_i;
            cod_p1 <= cod_p0;
        end
    end

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset)     div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DIV_W'(1);
    end

    // Tick stage: run-length measurement of the synchronised level
    logic       lvl;
    logic [7:0] hi_cnt, lo_cnt;
    logic       rise, fall, lo_step;
    assign rise    = tick &  cod_p1 & ~lvl;
    assign fall    = tick & ~cod_p1 &  lvl;
    assign lo_step = tick & ~cod_p1 & ~lvl;

    always_ff @(posedge clk) begin
        if (reset) begin
            lvl    <= 1'b0;
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else if (tick) begin
            lvl <= cod_p1;
            if (rise) begin
                hi_cnt <= 8'd1;
                lo_cnt <= 8'd0;
            end else if (cod_p1) begin
                hi_cnt <= sat_inc(hi_cnt);
            end else if (fall) begin
                lo_cnt <= 8'd1;
            end else begin
                lo_cnt <= sat_inc(lo_cnt);
            end
        end
    end

    // A rising edge after a sync-length low opens a frame and is not a pulse
    logic pulse_ev, is_s, is_g, pulse_bad, sync_ev, loss_ev;
    assign pulse_ev  = rise && (lo_cnt < 8'(SYNC_LO));
    assign is_s      = in_win(hi_cnt, 4) && in_win(lo_cnt, 12);
    assign is_g      = in_win(hi_cnt, 12) && in_win(lo_cnt, 4);
    assign pulse_bad = ~is_s & ~is_g;
    assign sync_ev   = lo_step && (lo_cnt == 8'(SYNC_LO - 1)) && in_win(hi_cnt, 4);
    assign loss_ev   = lo_step && (lo_cnt == 8'(LOSS_TICKS - 1));

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   sym_idx;
    logic               half, first_g;
    logic               abort, sym_done;
    logic [1:0]         sym_code;
    logic [2*ADDR_TRITS-1:0] rx_addr;
    logic [DATA_BITS-1:0]    rx_data;

    // Trit codes: 00 = 0, 01 = 1, 10 = F (short-long pair)
    assign sym_code = (first_g != is_g) ? 2'b10 : {1'b0, is_g};

    always_ff @(posedge clk) begin
        if (reset) state <= HUNT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        sym_done  = 1'b0;
        case (state)
            HUNT: begin
                if (sync_ev) state_nxt = RX;
            end
            RX: begin
                if (sync_ev) begin
                    if (sym_idx == IDX_W'(NSYM) && !half) state_nxt = CHECK;
                    else                                   abort = 1'b1;
                end else if (pulse_ev) begin
                    if (pulse_bad || sym_idx == IDX_W'(NSYM))              abort = 1'b1;
                    else if (half && first_g && !is_g)                      abort = 1'b1;
                    else if (half && sym_idx >= IDX_W'(ADDR_TRITS) && first_g != is_g)
                                                                            abort = 1'b1;
                    else if (half)                                          sym_done = 1'b1;
                end
            end
            CHECK:   state_nxt = RX;
            default: state_nxt = HUNT;
        endcase
        if (loss_ev) abort = 1'b1;
        if (abort)   state_nxt = HUNT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sym_idx <= '0;
            half    <= 1'b0;
        end else if (state != RX) begin
            sym_idx <= '0;
            half    <= 1'b0;
        end else if (pulse_ev) begin
            half <= ~half;
            if (sym_done) sym_idx <= sym_idx + IDX_W'(1);
        end
    end

    // Address trits fill from trit 0; data arrives MSB first
    always_ff @(posedge clk) begin
        if (pulse_ev && !half) first_g <= is_g;
        for (int i = 0; i < ADDR_TRITS; i++)
            if (sym_done && int'(sym_idx) == i) rx_addr[2*i +: 2] <= sym_code;
        for (int j = 0; j < DATA_BITS; j++)
            if (sym_done && int'(sym_idx) == NSYM - 1 - j) rx_data[j] <= is_g;
    end

    logic addr_ok;
    always_comb begin
        addr_ok = 1'b1;
        for (int i = 0; i < ADDR_TRITS; i++)
            if (rx_addr[2*i +: 2] != (A[2*i+1] ? 2'b10 : {1'b0, A[2*i]}))
                addr_ok = 1'b0;
    end

    // CHECK stage: repeat-match acceptance and output update
    logic [2:0]           mcnt, mcnt_inc;
    logic [DATA_BITS-1:0] cand;
    assign mcnt_inc = (mcnt < 3'(MATCH_COUNT)) ? mcnt + 3'd1 : mcnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            D    <= '0;
            dv   <= 1'b0;
            vt   <= 1'b0;
            mcnt <= '0;
            cand <= '0;
        end else begin
            dv <= 1'b0;
            if (abort) begin
                mcnt <= '0;
                vt   <= 1'b0;
                if (LATCH == 0) D <= '0;
            end else if (state == CHECK) begin
                if (!addr_ok) begin
                    mcnt <= '0;
                    vt   <= 1'b0;
                    if (LATCH == 0) D <= '0;
                end else if (rx_data == cand) begin
                    mcnt <= mcnt_inc;
                    if (mcnt_inc == 3'(MATCH_COUNT) && mcnt != 3'(MATCH_COUNT)) begin
                        D  <= cand;
                        dv <= 1'b1;
                        vt <= 1'b1;
                    end
                end else begin
                    cand <= rx_data;
                    mcnt <= 3'd1;
                    if (MATCH_COUNT == 1) begin
                        D  <= rx_data;
                        dv <= 1'b1;
                        vt <= 1'b1;
                    end else begin
                        vt <= 1'b0;
                        if (LATCH == 0) D <= '0;
                    end
                end
            end
        end
    end
endmodule
